bt_uart_rx: RTL and testbench

BT_UART_RX -- requirements
Module: bt_uart_rx

---
 rtl/bt_uart_pkg.sv | 19 +
 rtl/bt_baud_tick.sv | 35 +++
 rtl/bt_uart_rx.sv | 161 ++++++++++++++++
 tb/tb_bt_uart_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bt_uart_pkg.sv
// Shared constants and FSM state type for the Bluetooth UART receiver.
// BT_UART_PARITY_EN adds the PARITY state (8E1 frame); otherwise 8N1.
package bt_uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;
   localparam int DATA_BITS  = 8;

`ifdef BT_UART_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
   } state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_HIGH
   } state_e;
`endif

endpackage

// File: rtl/bt_baud_tick.sv
// 16x oversample tick generator: one-clk tick every CLK_DIV clocks while en,
// counter parked at zero when disabled so the first tick is a full period away.
module bt_baud_tick #(
   parameter int unsigned CLK_DIV = 27
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic tick
);

   localparam int unsigned   CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!en || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/bt_uart_rx.sv
// Oversampling UART receiver for a Bluetooth module link, mid-bit sampling.
// Define BT_UART_PARITY_EN for start/8 data/even parity/stop; default is 8N1.
module bt_uart_rx
   import bt_uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = 27
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] data_rx,
   output logic       rxrdy,
   output logic       framing_err,
   output logic       parity_err
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   logic                 sync1_q, sync2_q, prev_q;
   state_e               state_q, state_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic [BW-1:0]        bidx_q, bidx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [7:0]           data_q, data_d;
   logic                 rxrdy_q, rxrdy_d;
   logic                 ferr_q, ferr_d;
   logic                 tick, mid;
`ifdef BT_UART_PARITY_EN
   logic                 perr_q, perr_d;
   logic                 pbad_q, pbad_d;
`endif

   bt_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rstn (rstn),
      .en   (state_q != ST_IDLE),
      .tick (tick)
   );

   // The 8th tick after each bit boundary is the bit centre; tcnt wraps every bit.
   assign mid = tick && (tcnt_q == TW'(MID_SAMPLE - 1));

   always_comb begin
      state_d = state_q;
      tcnt_d  = tick ? tcnt_q + TW'(1) : tcnt_q;
      bidx_d  = bidx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      rxrdy_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef BT_UART_PARITY_EN
      perr_d  = 1'b0;
      pbad_d  = pbad_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tcnt_d = '0;
            if (prev_q && !sync2_q) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (mid) begin
               state_d = sync2_q ? ST_IDLE : ST_DATA;
               bidx_d  = '0;
            end
         end
         ST_DATA: begin
            if (mid) begin
               shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
               bidx_d  = bidx_q + BW'(1);
               if (bidx_q == BW'(DATA_BITS - 1)) begin
`ifdef BT_UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef BT_UART_PARITY_EN
         ST_PARITY: begin
            if (mid) begin
               pbad_d  = sync2_q ^ (^shreg_q);
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (mid) begin
               if (!sync2_q) begin
                  ferr_d  = 1'b1;
                  state_d = ST_WAIT_HIGH;
`ifdef BT_UART_PARITY_EN
                  perr_d  = pbad_q;
               end else if (pbad_q) begin
                  perr_d  = 1'b1;
                  state_d = ST_IDLE;
`endif
               end else begin
                  data_d  = shreg_q;
                  rxrdy_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT_HIGH: begin
            // A held-low line (break) must return high before a new start edge counts.
            if (sync2_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= ST_IDLE;
         tcnt_q  <= '0;
         bidx_q  <= '0;
         shreg_q <= '0;
         data_q  <= 8'h00;
         rxrdy_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef BT_UART_PARITY_EN
         perr_q  <= 1'b0;
         pbad_q  <= 1'b0;
`endif
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         bidx_q  <= bidx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         rxrdy_q <= rxrdy_d;
         ferr_q  <= ferr_d;
`ifdef BT_UART_PARITY_EN
         perr_q  <= perr_d;
         pbad_q  <= pbad_d;
`endif
      end
   end

   assign data_rx     = data_q;
   assign rxrdy       = rxrdy_q;
   assign framing_err = ferr_q;
`ifdef BT_UART_PARITY_EN
   assign parity_err  = perr_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed scoreboard bench for bt_uart_rx at CLK_DIV=4 (64 clk per bit).
module tb_bt_uart_rx;

   localparam int CLK_DIV  = 4;
   localparam int BIT_CLKS = CLK_DIV * 16;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic       rx   = 1'b1;
   logic [7:0] data_rx;
   logic       rxrdy, framing_err, parity_err;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         rdy_cnt = 0;
   int         ferr_cnt = 0;
   int         perr_cnt = 0;
   logic [7:0] exp_q[$];

   bt_uart_rx #(.CLK_DIV(CLK_DIV)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .rx          (rx),
      .data_rx     (data_rx),
      .rxrdy       (rxrdy),
      .framing_err (framing_err),
      .parity_err  (parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive_bits(input logic v, input int nbits);
      rx = v;
      repeat (nbits * BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_v,
                             input int stop_len);
      drive_bits(1'b0, 1);
      for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
`ifdef BT_UART_PARITY_EN
      drive_bits(par, 1);
`else
      if (par !== 1'bx) rx = rx;
`endif
      drive_bits(stop_v, stop_len);
   endtask

   task automatic send_good(input logic [7:0] b);
      exp_q.push_back(b);
      send_frame(b, ^b, 1'b1, 1);
   endtask

   // Monitor: pops the scoreboard on rxrdy, checks pulse widths and data hold.
   initial begin
      logic       rp = 1'b0, fp = 1'b0, pp = 1'b0, have = 1'b0;
      logic [7:0] last = 8'h00;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            have = 1'b0;
         end else begin
            if (rxrdy) begin
               rdy_cnt++;
               chk("rxrdy_width", 32'(rp), 0);
               chk("rxrdy_with_ferr", 32'(framing_err), 0);
               if (exp_q.size() == 0) begin
                  chk("rxrdy_unexpected_qsize", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  chk("data_rx", 32'(data_rx), 32'(e));
                  last = e;
                  have = 1'b1;
               end
            end else if (have) begin
               chk("data_hold", 32'(data_rx), 32'(last));
            end
            if (framing_err) begin
               ferr_cnt++;
               chk("ferr_width", 32'(fp), 0);
            end
            if (parity_err) begin
               perr_cnt++;
               chk("perr_width", 32'(pp), 0);
            end
         end
         rp = rxrdy;
         fp = framing_err;
         pp = parity_err;
      end
   end

   initial begin
      logic [7:0] partial;
      partial = 8'h5A;
      repeat (5) @(negedge clk);
      chk("reset_data_rx", 32'(data_rx), 0);
      chk("reset_rxrdy", 32'(rxrdy), 0);
      chk("reset_ferr", 32'(framing_err), 0);
      chk("reset_perr", 32'(parity_err), 0);
      rstn = 1'b1;
      drive_bits(1'b1, 2);

      // Single 0x55 frame
      send_good(8'h55);
      drive_bits(1'b1, 1);
      chk("rdy_cnt_55", rdy_cnt, 1);
      chk("ferr_cnt_55", ferr_cnt, 0);
      chk("data_55", 32'(data_rx), 32'h55);

      // Start-bit glitch of 4 ticks, then 0xA3
      rx = 1'b0;
      repeat (4 * CLK_DIV) @(negedge clk);
      drive_bits(1'b1, 2);
      chk("rdy_cnt_glitch", rdy_cnt, 1);
      chk("ferr_cnt_glitch", ferr_cnt, 0);
      send_good(8'hA3);
      drive_bits(1'b1, 1);
      chk("rdy_cnt_a3", rdy_cnt, 2);
      chk("data_a3", 32'(data_rx), 32'hA3);

      // 0x3C, then 0xA3 with stop held low for 20 bit times, then 0x11
      send_good(8'h3C);
      send_frame(8'hA3, ^8'hA3, 1'b0, 20);
      chk("ferr_cnt_break", ferr_cnt, 1);
      chk("rdy_cnt_break", rdy_cnt, 3);
      chk("data_keep_3c", 32'(data_rx), 32'h3C);
      drive_bits(1'b1, 2);
      send_good(8'h11);
      drive_bits(1'b1, 1);
      chk("rdy_cnt_11", rdy_cnt, 4);
      chk("ferr_cnt_11", ferr_cnt, 1);

      // Back-to-back frames with no idle gap
      send_good(8'h00);
      send_good(8'hFF);
      drive_bits(1'b1, 1);
      chk("rdy_cnt_b2b", rdy_cnt, 6);
      chk("data_ff", 32'(data_rx), 32'hFF);

      // Reset in the middle of bit 4
      drive_bits(1'b0, 1);
      for (int i = 0; i < 4; i++) drive_bits(partial[i], 1);
      rx = partial[4];
      repeat (BIT_CLKS / 2) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst_data_rx", 32'(data_rx), 0);
      chk("midrst_rxrdy", 32'(rxrdy), 0);
      chk("midrst_ferr", 32'(framing_err), 0);
      chk("midrst_perr", 32'(parity_err), 0);
      @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      drive_bits(1'b1, 2);
      chk("rdy_cnt_after_rst", rdy_cnt, 6);
      send_good(8'h81);
      drive_bits(1'b1, 1);
      chk("rdy_cnt_81", rdy_cnt, 7);
      chk("data_81", 32'(data_rx), 32'h81);

`ifdef BT_UART_PARITY_EN
      // Wrong parity, correct parity, then parity+framing together
      send_frame(8'h07, 1'b0, 1'b1, 1);
      drive_bits(1'b1, 1);
      chk("perr_cnt_bad07", perr_cnt, 1);
      chk("rdy_cnt_bad07", rdy_cnt, 7);
      chk("data_keep_81", 32'(data_rx), 32'h81);
      send_good(8'h07);
      drive_bits(1'b1, 1);
      chk("rdy_cnt_good07", rdy_cnt, 8);
      chk("data_07", 32'(data_rx), 32'h07);
      send_frame(8'h07, 1'b0, 1'b0, 2);
      drive_bits(1'b1, 1);
      chk("perr_cnt_both", perr_cnt, 2);
      chk("ferr_cnt_both", ferr_cnt, 2);
      chk("rdy_cnt_both", rdy_cnt, 8);
`else
      chk("perr_cnt_8n1", perr_cnt, 0);
      chk("perr_level_8n1", 32'(parity_err), 0);
`endif

      chk("queue_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
